// File: rtl/lsu_controller_if.sv
// Execute-side request/response channel and data-memory bus for lsu_controller.
// master drives requests (execute stage / controller); slave responds.
interface lsu_req_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic             resp_misalign;

    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                    input  req_ready, resp_valid, resp_rdata, resp_err, resp_misalign);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                    output req_ready, resp_valid, resp_rdata, resp_err, resp_misalign);
endinterface

interface lsu_mem_if #(parameter int WIDTH = 32);
    logic             mem_req;
    logic             mem_gnt;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_controller.sv
// RV32I load/store sequencer: one request in flight, req/gnt/rvalid memory handshake.
// Optional watchdog on the memory phase enabled by defining LSU_TIMEOUT_EN.
module lsu_controller #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  rq,
    lsu_mem_if.master mem,
    output logic      busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t     state;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;

    // Decode of the incoming request, used only on the accept cycle
    logic [1:0]       off;
    logic             misalign;
    logic [3:0]       be_n;
    logic [WIDTH-1:0] wdata_n;

    always_comb begin
        off      = rq.req_addr[1:0];
        misalign = 1'b0;
        be_n     = 4'b0000;
        wdata_n  = rq.req_wdata;
        case (rq.req_funct3)
            3'b000, 3'b100: begin
                be_n    = 4'b0001 << off;
                wdata_n = {4{rq.req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                be_n     = 4'b0011 << off;
                wdata_n  = {2{rq.req_wdata[15:0]}};
                misalign = off[0];
            end
            3'b010: begin
                be_n     = 4'b1111;
                misalign = (off != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] ld_data;

    always_comb begin
        shifted = mem.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
        if (we_q) ld_data = '0;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;
    logic          expired;
    assign expired = (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic expired;
    logic unused_timeout;
    assign expired        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            we_q              <= 1'b0;
            funct3_q          <= 3'b000;
            off_q             <= 2'b00;
            rq.req_ready      <= 1'b1;
            rq.resp_valid     <= 1'b0;
            rq.resp_rdata     <= '0;
            rq.resp_err       <= 1'b0;
            rq.resp_misalign  <= 1'b0;
            mem.mem_req       <= 1'b0;
            mem.mem_we        <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_be        <= 4'b0000;
            mem.mem_wdata     <= '0;
            busy              <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tcnt              <= '0;
`endif
        end else begin
`ifdef LSU_TIMEOUT_EN
            if (state == REQ || state == WAIT) tcnt <= tcnt + 1'b1;
`endif
            case (state)
                IDLE: if (rq.req_valid) begin
                    we_q         <= rq.req_we;
                    funct3_q     <= rq.req_funct3;
                    off_q        <= off;
                    rq.req_ready <= 1'b0;
                    busy         <= 1'b1;
                    if (misalign) begin
                        state            <= RESP;
                        rq.resp_valid    <= 1'b1;
                        rq.resp_misalign <= 1'b1;
                        rq.resp_err      <= 1'b0;
                        rq.resp_rdata    <= '0;
                    end else begin
                        state         <= REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= rq.req_we;
                        mem.mem_addr  <= {rq.req_addr[WIDTH-1:2], 2'b00};
                        mem.mem_be    <= be_n;
                        mem.mem_wdata <= wdata_n;
`ifdef LSU_TIMEOUT_EN
                        tcnt          <= '0;
`endif
                    end
                end
                REQ: if (mem.mem_gnt) begin
                    state       <= WAIT;
                    mem.mem_req <= 1'b0;
                end else if (expired) begin
                    state            <= RESP;
                    mem.mem_req      <= 1'b0;
                    rq.resp_valid    <= 1'b1;
                    rq.resp_err      <= 1'b1;
                    rq.resp_misalign <= 1'b0;
                    rq.resp_rdata    <= '0;
                end
                WAIT: if (mem.mem_rvalid) begin
                    state            <= RESP;
                    rq.resp_valid    <= 1'b1;
                    rq.resp_rdata    <= ld_data;
                    rq.resp_err      <= 1'b0;
                    rq.resp_misalign <= 1'b0;
                end else if (expired) begin
                    state            <= RESP;
                    rq.resp_valid    <= 1'b1;
                    rq.resp_err      <= 1'b1;
                    rq.resp_misalign <= 1'b0;
                    rq.resp_rdata    <= '0;
                end
                RESP: if (rq.resp_ready) begin
                    state         <= IDLE;
                    rq.resp_valid <= 1'b0;
                    rq.req_ready  <= 1'b1;
                    busy          <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
